parking_exit_gate: RTL and testbench
====================================

// Module: parking_exit_gate
// PURPOSE
//  Exit-side gate controller for the car park. A departing car is sensed at the exit
//  lane. The driver keys a 2x2-bit exit code. The block opens the barrier, reports the
//  departure to the occupancy logic and drives the lane lights and two 7-seg digits.
//  Companion to the entry-gate controller; consumes its car count as `occupancy`.
// PARAMETERS
//  WAIT_CYCLES  4      cycles spent in VERIFY before the code is sampled (>=1)
//  OPEN_CYCLES  8      max cycles barrier stays open waiting for sense_clear (>=1)
//  MAX_TRIES    3      wrong codes allowed before LOCKOUT (1..7)
//  EXIT_CODE    2'b10  required value on both exit_code_1 and exit_code_2
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-low reset
//  sense_exit   in   1  car present at exit barrier (level)
//  sense_clear  in   1  car has passed the barrier (level)
//  exit_code_1  in   2  keyed exit code, digit 1
//  exit_code_2  in   2  keyed exit code, digit 2
//  attendant_ok in   1  attendant override; only honoured in LOCKOUT
//  occupancy    in   4  cars currently parked, from the entry controller
//  gate_open    out  1  barrier open command
//  green_light  out  1  exit permitted
//  red_light    out  1  exit refused / locked
//  hex_1, hex_2 out  7  segments {g,f,e,d,c,b,a}, active-high
//  exit_pulse   out  1  one-cycle strobe per completed departure
//  phantom_err  out  1  one-cycle strobe: sense_exit rose while occupancy==0
//  cars_exited  out  8  total completed departures, wraps 255->0
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE. All outputs 0, hex 0000000. wait/open/try counters 0.
//  - Reset mid-operation closes the barrier immediately; no exit_pulse is generated.
//  - Outputs are registered and decoded from next_state: they change on the same edge
//    the state changes. exit_pulse and phantom_err are high for exactly one cycle.
//  - IDLE: gate 0, green 0, red 0, hex 0000000/0000000.
//    sense_exit & occupancy>0 -> VERIFY, wait counter cleared.
//    sense_exit & occupancy==0 -> stay IDLE, phantom_err pulses once per rising edge of sense_exit.
//  - VERIFY: green toggles each cycle, red 0, hex E/n (1111001/1010100). wait counter increments.
//    sense_exit=0 -> IDLE, tries cleared.
//    On the cycle wait==WAIT_CYCLES-1, both codes are sampled:
//      both == EXIT_CODE -> OPEN, open timer cleared.
//      otherwise -> DENIED, tries+1.
//  - OPEN: gate 1, green 1, red 0, hex G/0 (1111101/0111111). Open timer increments.
//    sense_clear=1 -> IDLE, exit_pulse=1, cars_exited+1, tries cleared.
//    Timer reaches OPEN_CYCLES-1 without clear -> IDLE, no pulse, no count.
//    Timeout and sense_clear in the same cycle: clear wins.
//  - DENIED: gate 0, green 0, red 1, hex E/E.
//    tries==MAX_TRIES -> LOCKOUT (checked first).
//    Else if sense_exit=0 -> IDLE, tries cleared.
//    Else if codes match -> VERIFY, wait counter cleared.
//  - LOCKOUT: gate 0, green 0, red toggles each cycle, hex L/L (0111000/0111000).
//    attendant_ok=1 -> OPEN, tries cleared. No other exit except reset.
//  - attendant_ok is ignored outside LOCKOUT. sense_clear is ignored outside OPEN.
//  - Counters saturate at their terminal value; there is no wrap except cars_exited.
//  - Illegal state encoding -> IDLE next cycle.
// TESTING
//  1. Happy path: occ=3, sense_exit=1, codes 10/10 -> VERIFY for 4 cycles, then OPEN, gate=1;
//     sense_clear=1 -> exit_pulse 1 cycle, cars_exited 0->1, IDLE.
//  2. Phantom: occ=0, sense_exit 0->1 -> phantom_err high 1 cycle, state stays IDLE, gate=0.
//  3. Lockout: codes 01/01 for 3 attempts -> DENIED x3 then LOCKOUT, red toggling, hex L/L;
//     attendant_ok=1 -> OPEN, gate=1.
//  4. Timeout: OPEN with sense_clear=0 for 8 cycles -> IDLE, gate=0, no exit_pulse,
//     cars_exited unchanged.
//  5. Async reset at the 3rd OPEN cycle -> gate=0 and all outputs 0 before the next edge;
//     cars_exited=0.
//  6. Wrap: preload 255 departures, one more departure -> cars_exited=0;
//     clear+timeout in same cycle -> exit_pulse=1.

Source files
------------

// File: rtl/parking_exit_gate_if.sv
// Lane-side signal bundle for the car park exit gate controller.
// The master drives the sensors, keypad and occupancy; the slave is the gate controller.
interface parking_exit_gate_if;
  logic       sense_exit;
  logic       sense_clear;
  logic [1:0] exit_code_1;
  logic [1:0] exit_code_2;
  logic       attendant_ok;
  logic [3:0] occupancy;
  logic       gate_open;
  logic       green_light;
  logic       red_light;
  logic [6:0] hex_1;
  logic [6:0] hex_2;
  logic       exit_pulse;
  logic       phantom_err;
  logic [7:0] cars_exited;

  modport master (
    output sense_exit, sense_clear, exit_code_1, exit_code_2, attendant_ok, occupancy,
    input  gate_open, green_light, red_light, hex_1, hex_2, exit_pulse, phantom_err, cars_exited
  );

  modport slave (
    input  sense_exit, sense_clear, exit_code_1, exit_code_2, attendant_ok, occupancy,
    output gate_open, green_light, red_light, hex_1, hex_2, exit_pulse, phantom_err, cars_exited
  );
endinterface

// File: rtl/parking_exit_gate.sv
// Exit-side barrier controller: code check, barrier timing, lockout and departure counting.
// All outputs are registered and decoded from the next state, so they move with the state.
module parking_exit_gate #(
  parameter int         WAIT_CYCLES = 4,
  parameter int         OPEN_CYCLES = 8,
  parameter int         MAX_TRIES   = 3,
  parameter logic [1:0] EXIT_CODE   = 2'b10
) (
  input logic                clk,
  input logic                rst,
  parking_exit_gate_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_VERIFY  = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_DENIED  = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);
  localparam int OPEN_W = $clog2(OPEN_CYCLES + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [OPEN_W-1:0] OPEN_LAST = OPEN_W'(OPEN_CYCLES - 1);
  localparam logic [2:0]        TRIES_MAX = 3'(MAX_TRIES);

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_E   = 7'b1111001;
  localparam logic [6:0] SEG_N   = 7'b1010100;
  localparam logic [6:0] SEG_G   = 7'b1111101;
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_L   = 7'b0111000;

  // Two-digit display pattern {hex_1, hex_2} shown in each state.
  function automatic logic [13:0] hex_pair(input logic [2:0] st);
    logic [13:0] pair;
    case (st)
      S_VERIFY:  pair = {SEG_E, SEG_N};
      S_OPEN:    pair = {SEG_G, SEG_0};
      S_DENIED:  pair = {SEG_E, SEG_E};
      S_LOCKOUT: pair = {SEG_L, SEG_L};
      default:   pair = {SEG_OFF, SEG_OFF};
    endcase
    return pair;
  endfunction

  logic [2:0]        state_r;
  logic [2:0]        next_state_s;
  logic [WAIT_W-1:0] wait_r;
  logic [WAIT_W-1:0] wait_nxt_s;
  logic [OPEN_W-1:0] open_r;
  logic [OPEN_W-1:0] open_nxt_s;
  logic [2:0]        tries_r;
  logic [2:0]        tries_nxt_s;
  logic              sense_prev_r;
  logic              codes_ok_s;
  logic              pulse_s;
  logic              phantom_s;

  logic              gate_r;
  logic              green_r;
  logic              red_r;
  logic [6:0]        hex_1_r;
  logic [6:0]        hex_2_r;
  logic              exit_pulse_r;
  logic              phantom_r;
  logic [7:0]        cars_r;

  assign codes_ok_s = (bus.exit_code_1 == EXIT_CODE) && (bus.exit_code_2 == EXIT_CODE);

  // Next-state, counter and strobe decisions for the current cycle.
  always_comb begin
    next_state_s = state_r;
    wait_nxt_s   = wait_r;
    open_nxt_s   = open_r;
    tries_nxt_s  = tries_r;
    pulse_s      = 1'b0;
    phantom_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.sense_exit && (bus.occupancy != 4'd0)) begin
          next_state_s = S_VERIFY;
          wait_nxt_s   = '0;
        end else if (bus.sense_exit && !sense_prev_r) begin
          // Only reachable with an empty car park: a car cannot be leaving.
          phantom_s = 1'b1;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_VERIFY: begin
        if (!bus.sense_exit) begin
          next_state_s = S_IDLE;
          tries_nxt_s  = 3'd0;
        end else if (wait_r >= WAIT_LAST) begin
          if (codes_ok_s) begin
            next_state_s = S_OPEN;
            open_nxt_s   = '0;
          end else begin
            next_state_s = S_DENIED;
            tries_nxt_s  = (tries_r >= TRIES_MAX) ? TRIES_MAX : tries_r + 3'd1;
          end
        end else begin
          wait_nxt_s = wait_r + WAIT_W'(1);
        end
      end
      S_OPEN: begin
        // A car clearing on the timeout cycle still counts as a departure.
        if (bus.sense_clear) begin
          next_state_s = S_IDLE;
          pulse_s      = 1'b1;
          tries_nxt_s  = 3'd0;
        end else if (open_r >= OPEN_LAST) begin
          next_state_s = S_IDLE;
        end else begin
          open_nxt_s = open_r + OPEN_W'(1);
        end
      end
      S_DENIED: begin
        if (tries_r == TRIES_MAX) begin
          next_state_s = S_LOCKOUT;
        end else if (!bus.sense_exit) begin
          next_state_s = S_IDLE;
          tries_nxt_s  = 3'd0;
        end else if (codes_ok_s) begin
          next_state_s = S_VERIFY;
          wait_nxt_s   = '0;
        end else begin
          next_state_s = S_DENIED;
        end
      end
      S_LOCKOUT: begin
        if (bus.attendant_ok) begin
          next_state_s = S_OPEN;
          open_nxt_s   = '0;
          tries_nxt_s  = 3'd0;
        end else begin
          next_state_s = S_LOCKOUT;
        end
      end
      default: begin
        next_state_s = S_IDLE;
        wait_nxt_s   = '0;
        open_nxt_s   = '0;
        tries_nxt_s  = 3'd0;
      end
    endcase
  end

  // State, counters and output registers; outputs follow next_state on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      wait_r       <= '0;
      open_r       <= '0;
      tries_r      <= 3'd0;
      sense_prev_r <= 1'b0;
      gate_r       <= 1'b0;
      green_r      <= 1'b0;
      red_r        <= 1'b0;
      hex_1_r      <= SEG_OFF;
      hex_2_r      <= SEG_OFF;
      exit_pulse_r <= 1'b0;
      phantom_r    <= 1'b0;
      cars_r       <= 8'd0;
    end else begin
      state_r      <= next_state_s;
      wait_r       <= wait_nxt_s;
      open_r       <= open_nxt_s;
      tries_r      <= tries_nxt_s;
      sense_prev_r <= bus.sense_exit;
      gate_r       <= (next_state_s == S_OPEN);
      green_r      <= (next_state_s == S_OPEN) || ((next_state_s == S_VERIFY) && !green_r);
      red_r        <= (next_state_s == S_DENIED) || ((next_state_s == S_LOCKOUT) && !red_r);
      {hex_1_r, hex_2_r} <= hex_pair(next_state_s);
      exit_pulse_r <= pulse_s;
      phantom_r    <= phantom_s;
      cars_r       <= pulse_s ? cars_r + 8'd1 : cars_r;
    end
  end

  assign bus.gate_open   = gate_r;
  assign bus.green_light = green_r;
  assign bus.red_light   = red_r;
  assign bus.hex_1       = hex_1_r;
  assign bus.hex_2       = hex_2_r;
  assign bus.exit_pulse  = exit_pulse_r;
  assign bus.phantom_err = phantom_r;
  assign bus.cars_exited = cars_r;

endmodule

// File: tb/tb_parking_exit_gate.sv
// Self-checking bench for parking_exit_gate: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model that tracks state by cycles-in-state.
module tb_parking_exit_gate;

  localparam int         WAIT_CYCLES = 4;
  localparam int         OPEN_CYCLES = 8;
  localparam int         MAX_TRIES   = 3;
  localparam logic [1:0] EXIT_CODE   = 2'b10;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_E   = 7'b1111001;
  localparam logic [6:0] SEG_N   = 7'b1010100;
  localparam logic [6:0] SEG_G   = 7'b1111101;
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_L   = 7'b0111000;

  localparam int M_IDLE = 0, M_VERIFY = 1, M_OPEN = 2, M_DENIED = 3, M_LOCK = 4;

  logic clk;
  logic rst;
  parking_exit_gate_if bus();

  parking_exit_gate #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .OPEN_CYCLES(OPEN_CYCLES),
    .MAX_TRIES  (MAX_TRIES),
    .EXIT_CODE  (EXIT_CODE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current phase and how many cycles it has lasted (1 = first cycle).
  int   m_st    = M_IDLE;
  int   m_k     = 0;
  int   m_tries = 0;
  int   m_cars  = 0;
  logic m_prev  = 1'b0;
  logic m_pulse = 1'b0;
  logic m_phantom = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [26:0] dut_vec();
    return {bus.gate_open, bus.green_light, bus.red_light, bus.hex_1, bus.hex_2,
            bus.exit_pulse, bus.phantom_err, bus.cars_exited};
  endfunction

  function automatic logic [26:0] exp_vec();
    logic       g, gr, r;
    logic [6:0] h1, h2;
    g = 1'b0; gr = 1'b0; r = 1'b0; h1 = SEG_OFF; h2 = SEG_OFF;
    case (m_st)
      M_VERIFY: begin gr = (m_k % 2) == 1; h1 = SEG_E; h2 = SEG_N; end
      M_OPEN:   begin g = 1'b1; gr = 1'b1; h1 = SEG_G; h2 = SEG_0; end
      M_DENIED: begin r = 1'b1; h1 = SEG_E; h2 = SEG_E; end
      M_LOCK:   begin r = (m_k % 2) == 0; h1 = SEG_L; h2 = SEG_L; end
      default:  begin g = 1'b0; end
    endcase
    return {g, gr, r, h1, h2, m_pulse, m_phantom, 8'(m_cars)};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_k = 0; m_tries = 0; m_cars = 0;
    m_prev = 1'b0; m_pulse = 1'b0; m_phantom = 1'b0;
  endtask

  task automatic model_step();
    int   nst;
    logic se, ok;
    se  = bus.sense_exit;
    ok  = (bus.exit_code_1 == EXIT_CODE) && (bus.exit_code_2 == EXIT_CODE);
    nst = m_st;
    m_pulse = 1'b0;
    m_phantom = 1'b0;
    case (m_st)
      M_IDLE: begin
        if (se && bus.occupancy > 0) nst = M_VERIFY;
        else if (se && !m_prev) m_phantom = 1'b1;
      end
      M_VERIFY: begin
        if (!se) begin nst = M_IDLE; m_tries = 0; end
        else if (m_k == WAIT_CYCLES) begin
          if (ok) nst = M_OPEN;
          else begin nst = M_DENIED; m_tries = (m_tries < MAX_TRIES) ? m_tries + 1 : MAX_TRIES; end
        end
      end
      M_OPEN: begin
        if (bus.sense_clear) begin
          nst = M_IDLE; m_pulse = 1'b1; m_cars = (m_cars + 1) % 256; m_tries = 0;
        end else if (m_k == OPEN_CYCLES) nst = M_IDLE;
      end
      M_DENIED: begin
        if (m_tries == MAX_TRIES) nst = M_LOCK;
        else if (!se) begin nst = M_IDLE; m_tries = 0; end
        else if (ok) nst = M_VERIFY;
      end
      M_LOCK: begin
        if (bus.attendant_ok) begin nst = M_OPEN; m_tries = 0; end
      end
      default: nst = M_IDLE;
    endcase
    m_prev = se;
    m_k = (nst != m_st) ? 1 : m_k + 1;
    m_st = nst;
  endtask

  // One clock: predict, let the edge happen, compare all outputs just after it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_val("outputs", 32'(dut_vec()), 32'(exp_vec()));
  endtask

  task automatic set_in(input logic se, input logic sc, input logic [1:0] c1,
                        input logic [1:0] c2, input logic att, input logic [3:0] occ);
    bus.sense_exit = se; bus.sense_clear = sc; bus.exit_code_1 = c1;
    bus.exit_code_2 = c2; bus.attendant_ok = att; bus.occupancy = occ;
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    set_in(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0);
    model_reset();
    #12;
    check_val("reset_state", 32'(dut_vec()), 32'd0);
    rst = 1'b1;

    // Happy path
    set_in(1'b1, 1'b0, EXIT_CODE, EXIT_CODE, 1'b0, 4'd3);
    repeat (5) tick();
    check_val("happy_gate", 32'(bus.gate_open), 32'd1);
    bus.sense_clear = 1'b1;
    tick();
    check_val("happy_pulse", 32'(bus.exit_pulse), 32'd1);
    check_val("happy_count", 32'(bus.cars_exited), 32'd1);
    set_in(1'b0, 1'b0, EXIT_CODE, EXIT_CODE, 1'b0, 4'd3);
    tick();
    check_val("happy_pulse_end", 32'(bus.exit_pulse), 32'd0);

    // Phantom departure from an empty car park
    set_in(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0);
    tick();
    bus.sense_exit = 1'b1;
    tick();
    check_val("phantom_hi", 32'(bus.phantom_err), 32'd1);
    tick();
    check_val("phantom_once", 32'(bus.phantom_err), 32'd0);
    check_val("phantom_gate", 32'(bus.gate_open), 32'd0);
    bus.sense_exit = 1'b0;
    tick();

    // Three wrong codes lead to lockout, attendant releases it
    set_in(1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 4'd5);
    repeat (5) tick();
    check_val("denied_red", 32'(bus.red_light), 32'd1);
    repeat (2) begin
      bus.exit_code_1 = EXIT_CODE; bus.exit_code_2 = EXIT_CODE;
      tick();
      bus.exit_code_1 = 2'b01; bus.exit_code_2 = 2'b01;
      repeat (4) tick();
    end
    tick();
    check_val("lock_hex", 32'({bus.hex_1, bus.hex_2}), 32'({SEG_L, SEG_L}));
    check_val("lock_red_a", 32'(bus.red_light), 32'd0);
    tick();
    check_val("lock_red_b", 32'(bus.red_light), 32'd1);
    bus.attendant_ok = 1'b1;
    tick();
    check_val("attendant_gate", 32'(bus.gate_open), 32'd1);

    // Barrier timeout with no clear
    set_in(1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 4'd5);
    repeat (OPEN_CYCLES) tick();
    check_val("timeout_gate", 32'(bus.gate_open), 32'd0);
    check_val("timeout_pulse", 32'(bus.exit_pulse), 32'd0);
    check_val("timeout_count", 32'(bus.cars_exited), 32'd1);

    // Asynchronous reset during the third open cycle
    set_in(1'b1, 1'b0, EXIT_CODE, EXIT_CODE, 1'b0, 4'd3);
    repeat (5 + 2) tick();
    check_val("pre_reset_gate", 32'(bus.gate_open), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("async_reset", 32'(dut_vec()), 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;

    // Preload 255 departures, then a departure on the timeout cycle wraps the count
    set_in(1'b1, 1'b1, EXIT_CODE, EXIT_CODE, 1'b0, 4'd9);
    guard = 0;
    while (m_cars != 255 && guard < 4000) begin tick(); guard++; end
    check_val("preload_count", 32'(bus.cars_exited), 32'd255);
    bus.sense_clear = 1'b0;
    guard = 0;
    while (!(m_st == M_OPEN && m_k == OPEN_CYCLES) && guard < 50) begin tick(); guard++; end
    bus.sense_clear = 1'b1;
    tick();
    check_val("wrap_pulse", 32'(bus.exit_pulse), 32'd1);
    check_val("wrap_count", 32'(bus.cars_exited), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.sense_exit   = ($urandom_range(0, 9) < 8);
      bus.sense_clear  = ($urandom_range(0, 9) < 2);
      bus.attendant_ok = ($urandom_range(0, 9) < 2);
      bus.occupancy    = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) < 6) begin
        bus.exit_code_1 = EXIT_CODE; bus.exit_code_2 = EXIT_CODE;
      end else begin
        bus.exit_code_1 = 2'($urandom_range(0, 3)); bus.exit_code_2 = 2'($urandom_range(0, 3));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
